mem_stage: RTL and testbench

//  Pipeline stage directly downstream of the execute stage. Registers the EX results and

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_stage_if.sv | 16 +
 rtl/mem_stage_align.sv | 57 +++++
 rtl/mem_stage.sv | 202 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 size codes, FSM
// encoding and MEM/WB bundle widths.
package mem_stage_pkg;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;

  // funct3[1:0] selects access size; funct3[2] selects zero-extension on loads
  localparam logic [1:0] F3_B = 2'b00;
  localparam logic [1:0] F3_H = 2'b01;
  localparam logic [1:0] F3_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Reserved encodings fall through to word size.
  function automatic size_t size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      F3_B:    size_of = SZ_B;
      F3_H:    size_of = SZ_H;
      F3_W:    size_of = SZ_W;
      default: size_of = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port with req/gnt/rvalid handshake.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_align.sv
// Combinational store lane/byte-enable generation, misalign check and
// load byte/half extraction with sign or zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] store_data,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic            misalign,
  input  logic [1:0]      ld_offset,
  input  logic [2:0]      ld_funct3,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data
);

  size_t      st_size;
  size_t      ld_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_size  = size_of(funct3);
    be       = 4'b0000;
    wdata    = '0;
    misalign = 1'b0;
    case (st_size)
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SZ_H: begin
        be       = 4'b0011 << addr_lo;
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
      end
      default: begin
        be       = 4'b1111;
        wdata    = store_data;
        misalign = |addr_lo;
      end
    endcase
  end

  always_comb begin
    ld_size = size_of(ld_funct3);
    ld_byte = rdata[{ld_offset, 3'b000} +: 8];
    ld_half = ld_offset[1] ? rdata[31:16] : rdata[15:0];
    case (ld_size)
      SZ_B:    load_data = ld_funct3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    load_data = ld_funct3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX results, runs loads/stores on the data-memory
// port, stalls upstream while an access is outstanding, and drives MEM/WB.
//
//   state   | meaning
//   IDLE    | accept EX; ALU ops and misaligned accesses retire next cycle
//   REQ     | dmem_req high from holding regs until gnt (or timeout)
//   WAIT    | load granted, waiting for rvalid (or timeout)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic [XLEN-1:0]   ex_pc_plus4,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [RF_AW-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_link,
  output logic              mem_stall,
  mem_stage_if.master       dmem,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [RF_AW-1:0]  wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_misalign,
  output logic              wb_bus_err
);

  localparam int CW = $clog2(TIMEOUT);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              h_we, h_rw;
  logic [XLEN-3:0]   h_word;
  logic [1:0]        h_off;
  logic [3:0]        h_be;
  logic [XLEN-1:0]   h_wdata;
  logic [2:0]        h_funct3;
  logic [RF_AW-1:0]  h_rd;

  logic [3:0]        a_be;
  logic [XLEN-1:0]   a_wdata, ld_data;
  logic              a_misalign, mem_op, timed_out, capture;
  logic              wb_fire, wb_rw_n, wb_mis_n, wb_err_n;
  logic [RF_AW-1:0]  wb_rd_n;
  logic [XLEN-1:0]   wb_data_n;

  mem_align u_align (
    .addr_lo    (ex_alu_result[1:0]),
    .funct3     (ex_funct3),
    .store_data (ex_rs2_data),
    .be         (a_be),
    .wdata      (a_wdata),
    .misalign   (a_misalign),
    .ld_offset  (h_off),
    .ld_funct3  (h_funct3),
    .rdata      (dmem.rdata),
    .load_data  (ld_data)
  );

  assign mem_op    = ex_mem_read | ex_mem_write;
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  // Bus outputs are gated by REQ so they read as zero in reset and when idle.
  assign dmem.req   = (state == ST_REQ);
  assign dmem.we    = dmem.req & h_we;
  assign dmem.addr  = dmem.req ? {h_word, 2'b00} : '0;
  assign dmem.be    = dmem.req ? h_be : 4'b0000;
  assign dmem.wdata = dmem.req ? h_wdata : '0;

  always_comb begin
    state_n   = state;
    capture   = 1'b0;
    mem_stall = 1'b0;
    wb_fire   = 1'b0;
    wb_rw_n   = wb_reg_write;
    wb_rd_n   = wb_rd;
    wb_data_n = wb_data;
    wb_mis_n  = wb_misalign;
    wb_err_n  = wb_bus_err;
    case (state)
      ST_IDLE: begin
        if (ex_valid) begin
          if (mem_op && !a_misalign) begin
            capture   = 1'b1;
            mem_stall = 1'b1;
            state_n   = ST_REQ;
          end else begin
            wb_fire   = 1'b1;
            wb_rd_n   = ex_rd;
            wb_data_n = ex_link ? ex_pc_plus4 : ex_alu_result;
            wb_mis_n  = mem_op;
            wb_err_n  = 1'b0;
            wb_rw_n   = !mem_op && ex_reg_write && (ex_rd != '0);
          end
        end
      end
      ST_REQ: begin
        mem_stall = 1'b1;
        if (dmem.gnt) begin
          if (h_we) begin
            wb_fire  = 1'b1;
            wb_rw_n  = 1'b0;
            wb_rd_n  = h_rd;
            wb_mis_n = 1'b0;
            wb_err_n = 1'b0;
            state_n  = ST_IDLE;
          end else begin
            state_n = ST_WAIT;
          end
        end else if (timed_out) begin
          wb_fire  = 1'b1;
          wb_rw_n  = 1'b0;
          wb_rd_n  = h_rd;
          wb_mis_n = 1'b0;
          wb_err_n = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        wb_rd_n   = h_rd;
        wb_mis_n  = 1'b0;
        if (dmem.rvalid) begin
          wb_fire   = 1'b1;
          wb_rw_n   = h_rw && (h_rd != '0);
          wb_data_n = ld_data;
          wb_err_n  = 1'b0;
          state_n   = ST_IDLE;
        end else if (timed_out) begin
          wb_fire  = 1'b1;
          wb_rw_n  = 1'b0;
          wb_err_n = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (state_n != state || state == ST_IDLE) cnt_n = '0;
    else                                      cnt_n = cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_we     <= 1'b0;
      h_rw     <= 1'b0;
      h_word   <= '0;
      h_off    <= 2'b00;
      h_be     <= 4'b0000;
      h_wdata  <= '0;
      h_funct3 <= 3'b000;
      h_rd     <= '0;
    end else if (capture) begin
      h_we     <= ex_mem_write;
      h_rw     <= ex_reg_write;
      h_word   <= ex_alu_result[XLEN-1:2];
      h_off    <= ex_alu_result[1:0];
      h_be     <= a_be;
      h_wdata  <= a_wdata;
      h_funct3 <= ex_funct3;
      h_rd     <= ex_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_misalign  <= 1'b0;
      wb_bus_err   <= 1'b0;
    end else begin
      wb_valid <= wb_fire;
      if (wb_fire) begin
        wb_reg_write <= wb_rw_n;
        wb_rd        <= wb_rd_n;
        wb_data      <= wb_data_n;
        wb_misalign  <= wb_mis_n;
        wb_bus_err   <= wb_err_n;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a short timeout so the
// bus-error path is reachable in a few cycles.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_link;
  logic [31:0] ex_alu_result, ex_rs2_data, ex_pc_plus4;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        mem_stall;
  logic        wb_valid, wb_reg_write, wb_misalign, wb_bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  int          checks, errors;

  mem_stage_if dmem ();
  assign dmem.gnt    = gnt;
  assign dmem.rvalid = rvalid;
  assign dmem.rdata  = rdata;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_rs2_data   (ex_rs2_data),
    .ex_pc_plus4   (ex_pc_plus4),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_link       (ex_link),
    .mem_stall     (mem_stall),
    .dmem          (dmem),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_misalign   (wb_misalign),
    .wb_bus_err    (wb_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_ex();
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_link = 0;
    ex_alu_result = 0; ex_rs2_data = 0; ex_pc_plus4 = 0; ex_funct3 = 0; ex_rd = 0;
  endtask

  task automatic drive_alu(input logic [31:0] res, input logic [31:0] pc4,
                           input logic [4:0] rd, input logic link);
    idle_ex();
    ex_valid = 1; ex_alu_result = res; ex_pc_plus4 = pc4; ex_rd = rd;
    ex_reg_write = 1; ex_link = link;
  endtask

  task automatic drive_mem(input logic is_load, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rd);
    idle_ex();
    ex_valid = 1; ex_alu_result = addr; ex_rs2_data = data; ex_funct3 = f3;
    ex_mem_read = is_load; ex_mem_write = !is_load; ex_rd = rd; ex_reg_write = is_load;
  endtask

  initial begin
    checks = 0; errors = 0;
    idle_ex();
    gnt = 0; rvalid = 0; rdata = 0; rst_n = 0;
    #3;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_req", dmem.req, 0);
    chk("rst_be", dmem.be, 0);
    chk("rst_stall", mem_stall, 0);
    #4 rst_n = 1;
    tick();

    // ALU op, 1-cycle latency, no stall
    drive_alu(32'h1234, 32'h0, 5'd5, 1'b0); #1;
    chk("alu_stall", mem_stall, 0);
    tick(); idle_ex(); #1;
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_rd", wb_rd, 5);
    chk("alu_wb_rw", wb_reg_write, 1);
    chk("alu_stall2", mem_stall, 0);
    tick(); #1;
    chk("alu_valid_drop", wb_valid, 0);

    // SB to 0x103, grant delayed
    drive_mem(1'b0, 3'b000, 32'h103, 32'hAABBCCDD, 5'd0); #1;
    chk("sb_stall_idle", mem_stall, 1);
    chk("sb_req_idle", dmem.req, 0);
    tick(); #1;
    chk("sb_req", dmem.req, 1);
    chk("sb_addr", dmem.addr, 32'h100);
    chk("sb_be", dmem.be, 32'h8);
    chk("sb_wdata", dmem.wdata, 32'hDDDDDDDD);
    chk("sb_we", dmem.we, 1);
    tick(); #1;
    chk("sb_req_hold", dmem.req, 1);
    chk("sb_no_early_wb", wb_valid, 0);
    gnt = 1;
    tick(); gnt = 0; idle_ex(); #1;
    chk("sb_wb_valid", wb_valid, 1);
    chk("sb_wb_rw", wb_reg_write, 0);
    chk("sb_req_after", dmem.req, 0);
    chk("sb_stall_after", mem_stall, 0);

    // SH to 0x102
    drive_mem(1'b0, 3'b001, 32'h102, 32'h1234ABCD, 5'd0);
    tick(); #1;
    chk("sh_be", dmem.be, 32'hC);
    chk("sh_wdata", dmem.wdata, 32'hABCDABCD);
    gnt = 1;
    tick(); gnt = 0; idle_ex(); #1;
    chk("sh_wb_valid", wb_valid, 1);

    // LB at 0x102, rvalid 3 cycles after gnt
    drive_mem(1'b1, 3'b000, 32'h102, 32'h0, 5'd7);
    tick(); gnt = 1; #1;
    chk("lb_req", dmem.req, 1);
    chk("lb_we", dmem.we, 0);
    chk("lb_addr", dmem.addr, 32'h100);
    tick(); gnt = 0; #1;
    chk("lb_wait_req", dmem.req, 0);
    chk("lb_wait_stall", mem_stall, 1);
    tick();
    tick(); rvalid = 1; rdata = 32'h0080_0000;
    tick(); rvalid = 0; rdata = 0; idle_ex(); #1;
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_wb_rd", wb_rd, 7);
    chk("lb_wb_rw", wb_reg_write, 1);
    chk("lb_stall_after", mem_stall, 0);

    // LBU, with a bogus rvalid alongside gnt that must be ignored
    drive_mem(1'b1, 3'b100, 32'h102, 32'h0, 5'd7);
    tick(); gnt = 1; rvalid = 1; rdata = 32'hFFFF_FFFF;
    tick(); gnt = 0; rvalid = 0; rdata = 0; #1;
    chk("lbu_no_early_valid", wb_valid, 0);
    tick();
    tick(); rvalid = 1; rdata = 32'h0080_0000;
    tick(); rvalid = 0; rdata = 0; idle_ex(); #1;
    chk("lbu_wb_valid", wb_valid, 1);
    chk("lbu_wb_data", wb_data, 32'h0000_0080);

    // Misaligned LW at 0x201
    drive_mem(1'b1, 3'b010, 32'h201, 32'h0, 5'd4); #1;
    chk("mis_stall", mem_stall, 0);
    chk("mis_req", dmem.req, 0);
    tick(); idle_ex(); #1;
    chk("mis_req_after", dmem.req, 0);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_misalign", wb_misalign, 1);
    chk("mis_wb_rw", wb_reg_write, 0);

    // Load granted but never answered: abort after 4 WAIT cycles
    drive_mem(1'b1, 3'b010, 32'h300, 32'h0, 5'd6);
    tick(); gnt = 1;
    tick(); gnt = 0; #1;
    chk("to_wait0_valid", wb_valid, 0);
    tick();
    tick();
    tick(); #1;
    chk("to_wait3_valid", wb_valid, 0);
    chk("to_wait3_stall", mem_stall, 1);
    tick(); drive_alu(32'h55, 32'h404, 5'd3, 1'b1); #1;
    chk("to_wb_valid", wb_valid, 1);
    chk("to_bus_err", wb_bus_err, 1);
    chk("to_wb_rw", wb_reg_write, 0);
    chk("to_misalign", wb_misalign, 0);
    chk("to_stall_alu", mem_stall, 0);
    tick(); idle_ex(); rvalid = 1; rdata = 32'h1111_1111; #1;
    chk("link_wb_valid", wb_valid, 1);
    chk("link_wb_data", wb_data, 32'h404);
    chk("link_bus_err", wb_bus_err, 0);
    chk("link_wb_rd", wb_rd, 3);
    tick(); rvalid = 0; rdata = 0; #1;
    chk("stray_rvalid", wb_valid, 0);

    // Reset during REQ
    drive_mem(1'b1, 3'b010, 32'h400, 32'h0, 5'd9);
    tick(); #1;
    chk("rs_req_before", dmem.req, 1);
    idle_ex(); gnt = 1; rst_n = 0; #1;
    chk("rs_req", dmem.req, 0);
    chk("rs_addr", dmem.addr, 0);
    chk("rs_be", dmem.be, 0);
    chk("rs_stall", mem_stall, 0);
    chk("rs_wb_valid", wb_valid, 0);
    chk("rs_wb_data", wb_data, 0);
    chk("rs_wb_rd", wb_rd, 0);
    tick(); gnt = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; rst_n = 1;
    tick(); rvalid = 0; rdata = 0; #1;
    chk("rs_stray_valid", wb_valid, 0);
    chk("rs_idle_req", dmem.req, 0);
    drive_mem(1'b1, 3'b010, 32'h400, 32'h0, 5'd9);
    tick(); gnt = 1;
    tick(); gnt = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
    tick(); rvalid = 0; rdata = 0; idle_ex(); #1;
    chk("rs_lw_valid", wb_valid, 1);
    chk("rs_lw_data", wb_data, 32'hCAFE_F00D);
    chk("rs_lw_rd", wb_rd, 9);
    chk("rs_lw_rw", wb_reg_write, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
